fft_bin_collector: RTL and testbench
====================================

FFT_BIN_COLLECTOR -- requirements
Module: fft_bin_collector

Interface
REQ-001 SHALL have parameter N, default 16: sample component width in bits, signed two's complement.
REQ-002 SHALL have parameter Q, default 8: fractional bits of the fixed-point format.
REQ-003 SHALL have parameter STAGES, default 4: number of FFT bins, also the width of the one-hot bin selector.
REQ-004 SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port i_out_instant, input, 2N bits: current FFT bin, re in [2N-1:N] and im in [N-1:0].
REQ-007 SHALL have port i_fft_out_switcher, input, STAGES bits: one-hot index of the bin on i_out_instant; all-zero means idle.
REQ-008 SHALL have port i_FFT_cycle_done, input, 1 bit: single-cycle pulse marking the end of an FFT output frame.
REQ-009 SHALL have port o_valid, output, 1 bit: frame results available.
REQ-010 SHALL have port i_ready, input, 1 bit: consumer accepts the results.
REQ-011 SHALL have port o_peak_idx, output, clog2(STAGES) bits: index of the bin with the largest power.
REQ-012 SHALL have port o_peak_pow, output, 2N bits: power of the peak bin.
REQ-013 SHALL have port i_rd_idx, input, clog2(STAGES) bits: bin-power read address.
REQ-014 SHALL have port o_rd_pow, output, 2N bits: power of bin i_rd_idx, combinational from the registered powers.
REQ-015 SHALL have port o_frame_err, output, 1 bit: one-cycle pulse when a frame is discarded as incomplete.
REQ-016 SHALL have port o_overrun, output, 1 bit: one-cycle pulse when input arrives while not collecting.

Function
REQ-017 SHALL implement the states COLLECT, MAG and HOLD; reset state is COLLECT.
REQ-018 In COLLECT, a cycle with exactly one switcher bit k set SHALL store i_out_instant into slot k and set bit k of the received mask; a later write to slot k overwrites it.
REQ-019 A non-one-hot, non-zero switcher value SHALL be ignored; no store, no flag.
REQ-020 In COLLECT, i_FFT_cycle_done SHALL take effect after any capture in the same cycle: if the mask is full, go to MAG; otherwise pulse o_frame_err, clear the mask, and stay in COLLECT.
REQ-021 In MAG, one bin per cycle SHALL be processed in ascending order, computing pow = (re*re + im*im) >> Q, truncated and zero-extended to 2N bits; the full 2N+1-bit sum SHALL be used before the shift.
REQ-022 MAG SHALL track the peak with strict greater-than, so on a tie the lowest index wins; it SHALL last exactly STAGES cycles.
REQ-023 o_valid SHALL rise in the cycle after the last MAG cycle, i.e. STAGES+1 cycles after the done edge, and the FSM SHALL enter HOLD.
REQ-024 In HOLD, o_valid, o_peak_idx, o_peak_pow and all powers SHALL stay stable until o_valid && i_ready.
REQ-025 On o_valid && i_ready the block SHALL clear o_valid and the mask next cycle and return to COLLECT.
REQ-026 In MAG or HOLD, a non-zero switcher or a done pulse SHALL pulse o_overrun, and that data SHALL be dropped.
REQ-027 o_frame_err and o_overrun in the same cycle SHALL be impossible by construction.

Reset
REQ-028 Asserting i_rst at any time, mid-frame included, SHALL force COLLECT, with mask, slots, powers, o_valid, o_peak_idx, o_peak_pow, o_frame_err and o_overrun all 0.
REQ-029 Operation SHALL resume on the first rising edge of i_clk after i_rst deasserts.

Structure
REQ-030 A shared package SHALL hold the defaults N=16, Q=8, STAGES=4 and the state enum COLLECT/MAG/HOLD.
REQ-031 Sub-module mag_sq SHALL hold the combinational (re^2+im^2)>>Q computation; it SHALL be instantiated once and time-shared across bins.

Verification
REQ-032 Bins in order 0..3 = (512,0), (256,-256), (0,0), (256,256), then done -> powers 1024, 512, 0, 512; peak_idx 0; peak_pow 1024; o_valid 5 cycles after done.
REQ-033 Bins 0,1,3 only, then done -> o_frame_err pulses once, o_valid stays 0, and the next full frame processes correctly.
REQ-034 Powers tied at bins 1 and 2 (re=256,im=0 each; others 0) -> peak_idx 1, peak_pow 256.
REQ-035 i_ready held low for 10 cycles while a new bin and done arrive -> o_overrun pulses, outputs unchanged, o_valid stays 1.
REQ-036 Bin (-32768,-32768) -> pow 0x0080_0000 with no overflow.
REQ-037 i_rst asserted during MAG -> all outputs 0 immediately, and a subsequent full frame gives correct results.

Source files
------------

// File: rtl/fft_bin_collector_pkg.sv
// Shared defaults and FSM state encoding for the FFT bin collector.
package fft_bin_collector_pkg;

   localparam int N_DEF      = 16;
   localparam int Q_DEF      = 8;
   localparam int STAGES_DEF = 4;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      MAG     = 2'd1,
      HOLD    = 2'd2
   } state_t;

endpackage

// File: rtl/fft_bin_collector_mag_sq.sv
// Combinational bin power: (re*re + im*im) >> Q, truncated to 2N bits.
module mag_sq
   import fft_bin_collector_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int Q = Q_DEF
) (
   input  logic [N-1:0]   re,
   input  logic [N-1:0]   im,
   output logic [2*N-1:0] pow
);

   logic signed [2*N-1:0] re_x;
   logic signed [2*N-1:0] im_x;
   logic signed [2*N-1:0] re_sq;
   logic signed [2*N-1:0] im_sq;
   logic        [2*N:0]   sum;

   assign re_x  = {{N{re[N-1]}}, re};
   assign im_x  = {{N{im[N-1]}}, im};
   assign re_sq = re_x * re_x;
   assign im_sq = im_x * im_x;

   // Squares are non-negative; the extra bit keeps (-2^(N-1))^2 * 2 from wrapping.
   assign sum = {1'b0, re_sq} + {1'b0, im_sq};
   assign pow = (2*N)'(sum >> Q);

endmodule

// File: rtl/fft_bin_collector.sv
// Collects one FFT output frame, computes per-bin power and the peak bin,
// then holds the results until the consumer accepts them.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   COLLECT | capture one-hot tagged bins; done checks mask completeness
//   MAG     | one bin per cycle through mag_sq, ascending, peak tracking
//   HOLD    | results stable, o_valid high until accepted
module fft_bin_collector
   import fft_bin_collector_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int Q      = Q_DEF,
   parameter int STAGES = STAGES_DEF,
   localparam int IW    = (STAGES > 1) ? $clog2(STAGES) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [2*N-1:0]    i_out_instant,
   input  logic [STAGES-1:0] i_fft_out_switcher,
   input  logic              i_FFT_cycle_done,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [IW-1:0]     o_peak_idx,
   output logic [2*N-1:0]    o_peak_pow,
   input  logic [IW-1:0]     i_rd_idx,
   output logic [2*N-1:0]    o_rd_pow,
   output logic              o_frame_err,
   output logic              o_overrun
);

   localparam logic [IW-1:0]     LAST_IDX = IW'(STAGES - 1);
   localparam logic [STAGES-1:0] SW_ONE   = STAGES'(1);

   state_t            state_q, state_d;
   logic [STAGES-1:0] mask_q, mask_d;
   logic [2*N-1:0]    slot_q [STAGES];
   logic [2*N-1:0]    pow_q  [STAGES];
   logic [IW-1:0]     bin_q;
   logic [IW-1:0]     peak_idx_q;
   logic [2*N-1:0]    peak_pow_q;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic              ovr_q, ovr_d;
   logic              cap_en;
   logic              mag_en;
   logic              sw_onehot;
   logic              sw_any;
   logic [IW-1:0]     sw_idx;
   logic [2*N-1:0]    cur_slot;
   logic [2*N-1:0]    mag_pow;

   always_comb begin
      sw_idx = '0;
      for (int k = 0; k < STAGES; k++) begin
         if (i_fft_out_switcher[k]) sw_idx = IW'(k);
      end
   end

   assign sw_any    = |i_fft_out_switcher;
   assign sw_onehot = sw_any &&
                      ((i_fft_out_switcher & (i_fft_out_switcher - SW_ONE)) == '0);

   assign cur_slot = slot_q[bin_q];

   mag_sq #(
      .N (N),
      .Q (Q)
   ) u_mag_sq (
      .re  (cur_slot[2*N-1:N]),
      .im  (cur_slot[N-1:0]),
      .pow (mag_pow)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      ovr_d   = 1'b0;
      cap_en  = 1'b0;
      mag_en  = 1'b0;
      case (state_q)
         COLLECT: begin
            if (sw_onehot) begin
               cap_en = 1'b1;
               mask_d = mask_q | i_fft_out_switcher;
            end
            // Completeness is judged after this cycle's capture.
            if (i_FFT_cycle_done) begin
               if (&mask_d) begin
                  state_d = MAG;
               end else begin
                  err_d  = 1'b1;
                  mask_d = '0;
               end
            end
         end
         MAG: begin
            mag_en = 1'b1;
            ovr_d  = sw_any || i_FFT_cycle_done;
            if (bin_q == LAST_IDX) begin
               state_d = HOLD;
               valid_d = 1'b1;
            end
         end
         HOLD: begin
            ovr_d = sw_any || i_FFT_cycle_done;
            if (valid_q && i_ready) begin
               valid_d = 1'b0;
               mask_d  = '0;
               state_d = COLLECT;
            end
         end
         default: begin
            state_d = COLLECT;
            mask_d  = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         mask_q     <= '0;
         bin_q      <= '0;
         peak_idx_q <= '0;
         peak_pow_q <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         ovr_q      <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            slot_q[k] <= '0;
            pow_q[k]  <= '0;
         end
      end else begin
         mask_q  <= mask_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
         if (cap_en) begin
            slot_q[sw_idx] <= i_out_instant;
         end
         if (mag_en) begin
            pow_q[bin_q] <= mag_pow;
            // Bin 0 seeds the peak; strict compare keeps the lowest index on ties.
            if ((bin_q == '0) || (mag_pow > peak_pow_q)) begin
               peak_pow_q <= mag_pow;
               peak_idx_q <= bin_q;
            end
            bin_q <= (bin_q == LAST_IDX) ? '0 : bin_q + IW'(1);
         end
      end
   end

   assign o_valid     = valid_q;
   assign o_peak_idx  = peak_idx_q;
   assign o_peak_pow  = peak_pow_q;
   assign o_rd_pow    = pow_q[i_rd_idx];
   assign o_frame_err = err_q;
   assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_fft_bin_collector.sv
// Directed bench for fft_bin_collector: vector table of full frames plus
// hand sequences for incomplete frames, overrun in HOLD and reset in MAG.
module tb_fft_bin_collector;

   localparam int N      = 16;
   localparam int Q      = 8;
   localparam int STAGES = 4;

   typedef struct packed {
      logic [3:0][15:0] re;
      logic [3:0][15:0] im;
      logic [3:0][31:0] pow;
      logic [1:0]       pk_idx;
      logic [31:0]      pk_pow;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst;
   logic [3:0]  sw;
   logic        done;
   logic        valid;
   logic        ready;
   logic [1:0]  peak_idx;
   logic [31:0] peak_pow;
   logic [1:0]  rd_idx;
   logic [31:0] rd_pow;
   logic        frame_err;
   logic        overrun;

   int   checks = 0;
   int   errors = 0;
   vec_t vecs [5];

   always #5 clk = ~clk;

   fft_bin_collector #(
      .N      (N),
      .Q      (Q),
      .STAGES (STAGES)
   ) dut (
      .i_clk              (clk),
      .i_rst              (rst_n),
      .i_out_instant      (inst),
      .i_fft_out_switcher (sw),
      .i_FFT_cycle_done   (done),
      .o_valid            (valid),
      .i_ready            (ready),
      .o_peak_idx         (peak_idx),
      .o_peak_pow         (peak_pow),
      .i_rd_idx           (rd_idx),
      .o_rd_pow           (rd_pow),
      .o_frame_err        (frame_err),
      .o_overrun          (overrun)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic setbin(input int v, input int k, input int re, input int im, input int pw);
      vecs[v].re[k]  = 16'(re);
      vecs[v].im[k]  = 16'(im);
      vecs[v].pow[k] = 32'(pw);
   endtask

   task automatic run_vec(input vec_t v, input bit done_with_last, input bit accept);
      int cyc;
      for (int k = 0; k < 4; k++) begin
         sw   = 4'(1 << k);
         inst = {v.re[k], v.im[k]};
         if (k == 3 && done_with_last) done = 1'b1;
         tick();
      end
      sw = 4'b0;
      if (!done_with_last) begin
         done = 1'b1;
         tick();
      end
      done = 1'b0;
      chk("no_frame_err", 32'(frame_err), 0);
      cyc = 1;
      while (!valid && cyc < 20) begin
         tick();
         cyc++;
      end
      chk("valid_latency", 32'(cyc), 5);
      for (int k = 0; k < 4; k++) begin
         rd_idx = 2'(k);
         #1;
         chk($sformatf("pow%0d", k), rd_pow, v.pow[k]);
      end
      chk("peak_idx", 32'(peak_idx), 32'(v.pk_idx));
      chk("peak_pow", peak_pow, v.pk_pow);
      if (accept) begin
         ready = 1'b1;
         tick();
         ready = 1'b0;
         chk("valid_clear", 32'(valid), 0);
      end
   endtask

   initial begin
      int ovr_cnt;
      int err_cnt;
      int val_seen;

      for (int i = 0; i < 5; i++) vecs[i] = '0;
      // Reference frame: 512^2>>8=1024, 2*256^2>>8=512
      setbin(0, 0, 512, 0, 1024);
      setbin(0, 1, 256, -256, 512);
      setbin(0, 3, 256, 256, 512);
      vecs[0].pk_idx = 2'd0; vecs[0].pk_pow = 32'd1024;
      // Tie at bins 1 and 2
      setbin(1, 1, 256, 0, 256);
      setbin(1, 2, 256, 0, 256);
      vecs[1].pk_idx = 2'd1; vecs[1].pk_pow = 32'd256;
      // Most negative components: 2*2^30 >> 8 = 2^23
      setbin(2, 2, -32768, -32768, 32'h0080_0000);
      vecs[2].pk_idx = 2'd2; vecs[2].pk_pow = 32'h0080_0000;
      // Truncation: 2>>8=0, 256>>8=1, 512>>8=2, 10009>>8=39
      setbin(3, 0, 1, 1, 0);
      setbin(3, 1, 16, 0, 1);
      setbin(3, 2, -16, -16, 2);
      setbin(3, 3, 100, -3, 39);
      vecs[3].pk_idx = 2'd3; vecs[3].pk_pow = 32'd39;
      // Tie at large magnitude: 32767^2 >> 8 = 4194048
      setbin(4, 1, 0, -32767, 4194048);
      setbin(4, 3, 32767, 0, 4194048);
      vecs[4].pk_idx = 2'd1; vecs[4].pk_pow = 32'd4194048;

      rst_n = 1'b0; inst = '0; sw = '0; done = 1'b0; ready = 1'b0; rd_idx = '0;
      repeat (3) tick();
      chk("rst_valid", 32'(valid), 0);
      chk("rst_peak_idx", 32'(peak_idx), 0);
      chk("rst_peak_pow", peak_pow, 0);
      chk("rst_rd_pow", rd_pow, 0);
      chk("rst_frame_err", 32'(frame_err), 0);
      chk("rst_overrun", 32'(overrun), 0);
      rst_n = 1'b1;
      tick();

      // Garbage in slot 0 later overwritten; non-one-hot ignored silently
      sw = 4'b0001; inst = 32'hDEAD_BEEF;
      tick();
      sw = 4'b0110; inst = 32'h7FFF_7FFF;
      tick();
      chk("nonhot_no_err", 32'(frame_err), 0);
      chk("nonhot_no_ovr", 32'(overrun), 0);
      run_vec(vecs[0], 1'b0, 1'b0);

      // HOLD with ready low: bin and done are dropped as overruns
      ovr_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         sw   = (c == 2) ? 4'b0100 : 4'b0000;
         inst = 32'h1234_5678;
         done = (c == 5);
         tick();
         if (overrun) ovr_cnt++;
         if (frame_err) ovr_cnt += 100;
      end
      sw = '0; done = 1'b0;
      tick();
      if (overrun) ovr_cnt++;
      chk("hold_overrun_cnt", 32'(ovr_cnt), 2);
      chk("hold_valid", 32'(valid), 1);
      chk("hold_peak_idx", 32'(peak_idx), 0);
      chk("hold_peak_pow", peak_pow, 1024);
      rd_idx = 2'd2;
      #1;
      chk("hold_pow2", rd_pow, 0);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("accept_valid", 32'(valid), 0);

      // Incomplete frame (0,1,3 plus a non-one-hot 0110) right after accept
      sw = 4'b0001; inst = 32'h0100_0000; tick();
      sw = 4'b0010; tick();
      sw = 4'b0110; tick();
      sw = 4'b1000; tick();
      sw = 4'b0000; done = 1'b1; tick();
      done = 1'b0;
      err_cnt  = frame_err ? 1 : 0;
      val_seen = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (frame_err) err_cnt++;
         if (valid) val_seen++;
      end
      chk("partial_err_cnt", 32'(err_cnt), 1);
      chk("partial_no_valid", 32'(val_seen), 0);

      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i], (i == 3), 1'b1);
      end

      // Reset asserted during MAG, after bin 0 has produced a non-zero peak
      for (int k = 0; k < 4; k++) begin
         sw = 4'(1 << k); inst = {vecs[0].re[k], vecs[0].im[k]};
         tick();
      end
      sw = '0; done = 1'b1; tick();
      done = 1'b0;
      rd_idx = 2'd0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", 32'(valid), 0);
      chk("mrst_peak_idx", 32'(peak_idx), 0);
      chk("mrst_peak_pow", peak_pow, 0);
      chk("mrst_rd_pow", rd_pow, 0);
      chk("mrst_err_ovr", {30'd0, frame_err, overrun}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      run_vec(vecs[0], 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
